truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
Sequencer that exercises a combinational N-input, 1-output logic block, such as the team's boolean_expr, in hardware. On a start request it drives every input combination in ascending order and waits a programmable settle time per vector. It then samples the block's output into a truth-table register and compares the result with an expected table. It sits beside the logic block as a built-in self-test / characterisation controller.

Parameters:
N_IN, 3, number of inputs of the logic block under control; NVEC = 2**N_IN vectors.
SETTLE, 2, cycles each vector is held before sampling; legal range 1..15.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a sweep; sampled only in IDLE.
expected  input  NVEC  expected truth table; bit i = expected output for input vector i; captured when start is accepted.
din  output  N_IN  input vector driven to the logic block; MSB = A, LSB = C for N_IN=3.
y_in  input  1  output of the logic block.
busy  output  1  high while a sweep is in progress.
done  output  1  one-cycle pulse when a sweep completes.
pass  output  1  1 when measured table == captured expected; valid from the done cycle.
table_out  output  NVEC  measured truth table.
mismatch  output  NVEC  table_out XOR captured expected.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. Reset asserts immediately and is released synchronously to clk.
- Reset values: state=IDLE; din=0; busy=0; done=0; pass=0; table_out=0; mismatch=0; vector index=0; settle count=0; expected register=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: busy=0 and din=0.
  - start=1 at an edge: capture expected; clear table_out and mismatch; clear pass; set index=0; go to DRIVE.
- DRIVE:
  - din=index; busy=1.
  - Settle count runs 0..SETTLE-1. At SETTLE-1, go to SAMPLE.
- SAMPLE:
  - din=index is held; busy=1.
  - table_out[index] <= y_in.
  - If index==NVEC-1, go to DONE. Otherwise index++, clear the settle count, and go to DRIVE.
- DONE:
  - done=1 for exactly this cycle; busy=0; din=0.
  - pass and mismatch are registered on entry to DONE, so they are valid while done=1. They are computed from the complete table, including the final sampled bit.
  - Next state is IDLE.
- Latency:
  - Each vector takes SETTLE+1 cycles.
  - If start is accepted at edge k, done is high in the cycle after edge k+NVEC*(SETTLE+1).
  - Default parameters: done follows the accept edge by 25 cycles.
- Result hold: table_out, mismatch and pass keep their values until the next accepted start clears them.
- start while busy, or during DONE, is ignored. Start is not queued.
- start held high continuously: a new sweep begins in the cycle after DONE returns to IDLE, i.e. back-to-back sweeps with one IDLE cycle between them.
- expected changing mid-sweep has no effect; only the captured copy is used.
- Index arithmetic: the index is N_IN bits wide. Completion is detected by comparing with NVEC-1, not by wrap-around, so the index never wraps during a sweep.
- Reset mid-sweep: the block returns to reset values immediately, with no done pulse and no partial results retained.
- y_in is sampled only in SAMPLE. It is never sampled in DRIVE, so glitches during settling are ignored.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, DRIVE, SAMPLE, DONE);
  - localparam NVEC derived from N_IN;
  - the settle-counter width constant (4 bits).
- One natural sub-module: sweep_settle_timer, a loadable down-counter that asserts expire after SETTLE cycles. It is reused by later sequencers.
- The controlled logic block is instantiated outside the sweeper, at the bench or top level, and connected through din/y_in.

Test Plan:
- Reset, then start=1 for one cycle with the logic block = A&B|C and expected=8'hEA:
  - din steps 0..7, each held 3 cycles;
  - done pulses 25 cycles after the accept edge;
  - table_out=8'hEA, mismatch=0, pass=1.
- Same logic block with expected=8'hEB:
  - done pulses 25 cycles after the accept edge;
  - table_out=8'hEA, mismatch=8'h01, pass=0.
- Pulse start again at cycle 10 of a running sweep, and change expected to 8'h00 mid-sweep:
  - the second start is ignored;
  - only one done pulse occurs;
  - pass=1 against the captured 8'hEA.
- Hold start high:
  - two sweeps run back-to-back with one IDLE cycle between DONE and the next DRIVE;
  - table_out is cleared to 0 at the second accept edge.
- Assert rst_n=0 asynchronously during vector 4:
  - din, busy, table_out and pass go to 0 immediately;
  - no done pulse occurs;
  - a later start completes normally.
- Instantiate with SETTLE=1:
  - each vector is held 2 cycles;
  - done follows the accept edge by 17 cycles.
- Insert a glitch on y_in during DRIVE only:
  - table_out is unaffected.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper and its helpers.
package truth_table_sweeper_pkg;

   // Sweep sequencer states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_e;

   // Default number of inputs of the logic block under control.
   localparam int N_IN_DEF = 3;

   // Settle counter width; covers settle times 1..15.
   localparam int CNT_W = 4;

   // Number of input vectors of an n_in-input block.
   function automatic int nvec_of(input int n_in);
      return 1 << n_in;
   endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter: after a load of SETTLE-1, expire_o rises once the
// counter has been enabled for SETTLE cycles (including the first cycle
// following the load).
module sweep_settle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         expire_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Load has priority; counting stops at zero so expire stays asserted.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_o = (count_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Built-in self-test sequencer: walks every input vector of an external
// N_IN-input combinational block, samples its output after a settle time
// and compares the measured truth table against a captured expectation.
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int SETTLE = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   expected,
   output logic [N_IN-1:0]      din,
   input  logic                 y_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2**N_IN-1:0]   table_out,
   output logic [2**N_IN-1:0]   mismatch
);

   localparam int               NVEC        = nvec_of(N_IN);
   localparam logic [N_IN-1:0]  LAST_IDX    = N_IN'(NVEC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

   state_e            state_q, state_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic [NVEC-1:0]   exp_q, exp_d;
   logic [NVEC-1:0]   tbl_q, tbl_d;
   logic [NVEC-1:0]   mis_q, mis_d;
   logic              pass_q, pass_d;
   logic              tmr_load;
   logic              tmr_en;
   logic              tmr_expire;

   sweep_settle_timer #(
      .W (CNT_W)
   ) u_settle (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (SETTLE_LOAD),
      .en_i       (tmr_en),
      .expire_o   (tmr_expire)
   );

   // Next-state logic: sequencing, result capture and settle-timer control.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      exp_d    = exp_q;
      tbl_d    = tbl_q;
      mis_d    = mis_q;
      pass_d   = pass_q;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               exp_d    = expected;
               tbl_d    = '0;
               mis_d    = '0;
               pass_d   = 1'b0;
               idx_d    = '0;
               tmr_load = 1'b1;
               state_d  = DRIVE;
            end
         end
         DRIVE: begin
            tmr_en = 1'b1;
            if (tmr_expire) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            tbl_d[idx_q] = y_in;
            if (idx_q == LAST_IDX) begin
               // Compare against the table including the bit sampled now.
               mis_d   = tbl_d ^ exp_q;
               pass_d  = (tbl_d == exp_q);
               state_d = DONE;
            end else begin
               idx_d    = idx_q + 1'b1;
               tmr_load = 1'b1;
               state_d  = DRIVE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         exp_q   <= '0;
         tbl_q   <= '0;
         mis_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         exp_q   <= exp_d;
         tbl_q   <= tbl_d;
         mis_q   <= mis_d;
         pass_q  <= pass_d;
      end
   end

   assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
   assign done      = (state_q == DONE);
   assign din       = busy ? idx_q : '0;
   assign pass      = pass_q;
   assign table_out = tbl_q;
   assign mismatch  = mis_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper driving the block y = A&B | C
// (A = din[2], C = din[0]), whose truth table is 8'hEA.
module tb_truth_table_sweeper;

   logic       clk;
   logic       rst_n;

   logic       start_a, start_b;
   logic [7:0] exp_a, exp_b;
   logic [2:0] din_a, din_b;
   logic       y_a, y_b;
   logic       glitch_a;
   logic       busy_a, busy_b;
   logic       done_a, done_b;
   logic       pass_a, pass_b;
   logic [7:0] tbl_a, tbl_b;
   logic [7:0] mis_a, mis_b;

   int checks   = 0;
   int failures = 0;

   truth_table_sweeper #(.N_IN(3), .SETTLE(2)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_a),
      .expected  (exp_a),
      .din       (din_a),
      .y_in      (y_a),
      .busy      (busy_a),
      .done      (done_a),
      .pass      (pass_a),
      .table_out (tbl_a),
      .mismatch  (mis_a)
   );

   truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_b),
      .expected  (exp_b),
      .din       (din_b),
      .y_in      (y_b),
      .busy      (busy_b),
      .done      (done_b),
      .pass      (pass_b),
      .table_out (tbl_b),
      .mismatch  (mis_b)
   );

   // Logic block under control; glitch_a disturbs only DUT A's input.
   assign y_a = ((din_a[2] & din_a[1]) | din_a[0]) ^ glitch_a;
   assign y_b =  (din_b[2] & din_b[1]) | din_b[0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One sweep on DUT A. Sample point n is #1 after the n-th edge following
   // the accept edge (n=0 is the accept edge itself). Vector v occupies
   // n = 3v..3v+2 with SAMPLE at n%3==2; DONE appears at n=24.
   task automatic sweep_a(input logic [7:0] exp_v, input int poke_at, input bit glitch_en,
                          output int lat, output int ndone, output int din_bad,
                          output int busy_bad, output logic pass_dn,
                          output logic [7:0] mis_dn, output logic [7:0] tbl_dn);
      lat = -1; ndone = 0; din_bad = 0; busy_bad = 0;
      pass_dn = 1'bx; mis_dn = 'x; tbl_dn = 'x;
      @(negedge clk);
      start_a = 1'b1;
      exp_a   = exp_v;
      @(posedge clk);
      for (int n = 0; n < 30; n++) begin
         if (n > 0) @(posedge clk);
         #1;
         if (n < 24) begin
            if (din_a !== 3'(n / 3)) din_bad++;
            if (busy_a !== 1'b1) busy_bad++;
         end
         if (done_a === 1'b1) begin
            ndone++;
            if (lat < 0) begin
               lat = n; pass_dn = pass_a; mis_dn = mis_a; tbl_dn = tbl_a;
            end
         end
         if (n == 0) start_a = 1'b0;
         if (n == poke_at) begin
            start_a = 1'b1;
            exp_a   = 8'h00;
         end
         if (n == poke_at + 1) start_a = 1'b0;
         glitch_a = glitch_en && (n < 24) && ((n % 3) != 2);
      end
      glitch_a = 1'b0;
   endtask

   initial begin
      int lat, ndone, din_bad, busy_bad, nd, bad;
      logic pass_dn;
      logic [7:0] mis_dn, tbl_dn;

      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
      exp_a = 8'h00; exp_b = 8'h00; glitch_a = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_din",   din_a,  3'd0);
      chk("rst_busy",  busy_a, 1'b0);
      chk("rst_done",  done_a, 1'b0);
      chk("rst_pass",  pass_a, 1'b0);
      chk("rst_table", tbl_a,  8'h00);
      chk("rst_mis",   mis_a,  8'h00);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Matching expectation.
      sweep_a(8'hEA, -1, 1'b0, lat, ndone, din_bad, busy_bad, pass_dn, mis_dn, tbl_dn);
      chk("t1_latency",  lat,      24);
      chk("t1_ndone",    ndone,    1);
      chk("t1_din_seq",  din_bad,  0);
      chk("t1_busy",     busy_bad, 0);
      chk("t1_table",    tbl_dn,   8'hEA);
      chk("t1_mismatch", mis_dn,   8'h00);
      chk("t1_pass",     pass_dn,  1'b1);
      chk("t1_hold_tbl", tbl_a,    8'hEA);
      chk("t1_hold_pass", pass_a,  1'b1);
      chk("t1_idle_din", din_a,    3'd0);

      // Expectation differing in bit 0.
      sweep_a(8'hEB, -1, 1'b0, lat, ndone, din_bad, busy_bad, pass_dn, mis_dn, tbl_dn);
      chk("t2_latency",  lat,    24);
      chk("t2_table",    tbl_dn, 8'hEA);
      chk("t2_mismatch", mis_dn, 8'h01);
      chk("t2_pass",     pass_dn, 1'b0);

      // Restart request and expected change mid-sweep are ignored.
      sweep_a(8'hEA, 10, 1'b0, lat, ndone, din_bad, busy_bad, pass_dn, mis_dn, tbl_dn);
      chk("t3_latency",  lat,     24);
      chk("t3_ndone",    ndone,   1);
      chk("t3_din_seq",  din_bad, 0);
      chk("t3_pass",     pass_dn, 1'b1);
      chk("t3_mismatch", mis_dn,  8'h00);
      chk("t3_busy_after", busy_a, 1'b0);

      // Glitches during DRIVE only do not reach the table.
      sweep_a(8'hEA, -1, 1'b1, lat, ndone, din_bad, busy_bad, pass_dn, mis_dn, tbl_dn);
      chk("t4_table", tbl_dn,  8'hEA);
      chk("t4_pass",  pass_dn, 1'b1);

      // start held high: DONE, one IDLE cycle, then the next accept.
      @(negedge clk);
      start_a = 1'b1;
      exp_a   = 8'hEA;
      @(posedge clk);
      repeat (24) @(posedge clk);
      #1;
      chk("t5_done",      done_a, 1'b1);
      chk("t5_tbl_done",  tbl_a,  8'hEA);
      @(posedge clk); #1;
      chk("t5_idle_busy", busy_a, 1'b0);
      chk("t5_idle_done", done_a, 1'b0);
      chk("t5_idle_tbl",  tbl_a,  8'hEA);
      @(posedge clk); #1;
      chk("t5_re_busy",   busy_a, 1'b1);
      chk("t5_re_tbl",    tbl_a,  8'h00);
      chk("t5_re_din",    din_a,  3'd0);
      start_a = 1'b0;
      nd = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         if (done_a === 1'b1) nd++;
      end
      chk("t5_second_done", nd, 1);
      chk("t5_second_tbl",  tbl_a, 8'hEA);

      // Asynchronous reset during vector 4.
      @(negedge clk);
      start_a = 1'b1;
      exp_a   = 8'hEA;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (13) @(posedge clk);
      #1;
      chk("t6_pre_din", din_a, 3'd4);
      chk("t6_pre_tbl", tbl_a, 8'h0A);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_din",  din_a,  3'd0);
      chk("t6_rst_busy", busy_a, 1'b0);
      chk("t6_rst_tbl",  tbl_a,  8'h00);
      chk("t6_rst_pass", pass_a, 1'b0);
      chk("t6_rst_done", done_a, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         if (done_a === 1'b1) nd++;
      end
      chk("t6_no_done", nd, 0);
      sweep_a(8'hEA, -1, 1'b0, lat, ndone, din_bad, busy_bad, pass_dn, mis_dn, tbl_dn);
      chk("t6_after_latency", lat,    24);
      chk("t6_after_table",   tbl_dn, 8'hEA);
      chk("t6_after_pass",    pass_dn, 1'b1);

      // SETTLE=1: two cycles per vector, DONE at n=16.
      @(negedge clk);
      start_b = 1'b1;
      exp_b   = 8'hEA;
      @(posedge clk);
      lat = -1; bad = 0; pass_dn = 1'bx; tbl_dn = 'x;
      for (int n = 0; n < 24; n++) begin
         if (n > 0) @(posedge clk);
         #1;
         if (n == 0) start_b = 1'b0;
         if (n < 16 && din_b !== 3'(n / 2)) bad++;
         if (done_b === 1'b1 && lat < 0) begin
            lat = n; pass_dn = pass_b; tbl_dn = tbl_b;
         end
      end
      chk("t7_latency", lat,     16);
      chk("t7_din_seq", bad,     0);
      chk("t7_table",   tbl_dn,  8'hEA);
      chk("t7_pass",    pass_dn, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
